mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, alongside the integer ALU. It takes the same register-read operands as the ALU and runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, one radix-2 step per clock. It returns a registered result to the writeback mux with a one-cycle valid pulse. Control stalls fetch/decode while `busy` is high.

---
 rtl/mul_div_pkg.sv | 22 ++
 rtl/mul_div_unit.sv | 168 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 op codes and the controller state set.
package mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide: shift-add multiply (LSB first), restoring divide
// (MSB first) on magnitudes, then a sign-fix cycle that loads the registered result.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    input  logic                  kill,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    state_e          state_q;
    op_e             op_q;
    logic            neg_q;
    logic            rem_neg_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    mcand_q;
    logic [W-1:0]    result_q;
    logic            valid_q;
    logic            busy_q;

    // Accept-side decode of the incoming request
    op_e          op_in;
    logic         a_signed, b_signed, a_neg, b_neg, is_div_in, div_zero, div_ovf;
    logic [W-1:0] a_mag, b_mag;

    always_comb begin
        op_in     = op_e'(op);
        is_div_in = op[2];
        a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg     = a_signed & operand_A[W-1];
        b_neg     = b_signed & operand_B[W-1];
        a_mag     = neg_w(operand_A, a_neg);
        b_mag     = neg_w(operand_B, b_neg);
        div_zero  = is_div_in && (operand_B == '0);
        div_ovf   = is_div_in && b_signed && (operand_A == MOST_NEG) && (operand_B == '1);
    end

    // One iteration step; acc holds {partial/remainder, multiplier/quotient}
    logic [W:0]     mul_sum, div_trial, div_diff;
    logic [2*W-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_trial = acc_q[2*W-1:W-1];
        div_diff  = div_trial - {1'b0, mcand_q};
        div_next  = div_diff[W] ? {div_trial[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
    end

    // Sign correction and word select
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = neg_2w(acc_q, neg_q);
        quot_fix = neg_w(acc_q[W-1:0], neg_q);
        rem_fix  = neg_w(acc_q[2*W-1:W], rem_neg_q);
        unique case (op_q)
            OP_MUL:                       fix_result = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_result = quot_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q      <= op_in;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        // Special divides preset acc so the fix cycle passes it through
                        if (div_zero) begin
                            acc_q     <= {operand_A, {W{1'b1}}};
                            neg_q     <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= FIX;
                        end else if (div_ovf) begin
                            acc_q     <= {{W{1'b0}}, operand_A};
                            neg_q     <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= FIX;
                        end else if (is_div_in) begin
                            acc_q   <= {{W{1'b0}}, a_mag};
                            mcand_q <= b_mag;
                            state_q <= CALC;
                        end else begin
                            acc_q   <= {{W{1'b0}}, b_mag};
                            mcand_q <= a_mag;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= op_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!kill) begin
                        result_q <= fix_result;
                        valid_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of op vectors with result/latency checks,
// plus kill, back-to-back and mid-operation reset sequences.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] operand_A = '0;
    logic [W-1:0] operand_B = '0;
    logic         kill = 1'b0;
    logic         busy, valid;
    logic [W-1:0] result;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_A(operand_A), .operand_B(operand_B), .kill(kill),
        .busy(busy), .valid(valid), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        op_e          vop;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Called #1 after an edge; returns #1 after the accept edge
    task automatic start_op(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; operand_A = a; operand_B = b;
        @(posedge clock); #1;
        start = 1'b0;
        operand_A = $urandom; operand_B = $urandom; op = 3'($urandom);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("valid_low_after_accept", {31'b0, valid}, 32'd0);
    endtask

    task automatic wait_done(output logic [W-1:0] res, output int lat, output int bcnt);
        lat = 0; bcnt = 0; res = 'x;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            lat++;
            if (valid) begin
                res = result;
                return;
            end
            if (busy) bcnt++;
        end
        lat = -1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [W-1:0] res;
        int lat, bcnt;
        start_op(v.vop, v.a, v.b);
        wait_done(res, lat, bcnt);
        chk({name, "_result"}, res, v.exp);
        chk({name, "_latency"}, W'(lat), W'(v.lat));
        chk({name, "_busy_cycles"}, W'(bcnt), W'(v.lat - 1));
        chk({name, "_busy_low_at_valid"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (valid) n++;
        end
    endtask

    initial begin
        logic [W-1:0] res, held;
        int lat, bcnt, nv;

        vecs.push_back('{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back('{OP_MULHU,  32'h80000000, 32'd2,        32'h00000001, 33});
        vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{OP_DIVU,   32'd7,        32'd2,        32'd3,        33});
        vecs.push_back('{OP_REMU,   32'd7,        32'd2,        32'd1,        33});
        vecs.push_back('{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vecs.push_back('{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33});
        vecs.push_back('{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33});
        vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{OP_REMU,   32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1});
        vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Kill ten cycles into CALC: no completion, result holds
        held = result;
        start_op(OP_MULHU, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clock);
        #1;
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_valid", {31'b0, valid}, 32'd0);
        chk("kill_result_held", result, held);
        count_valids(40, nv);
        chk("kill_no_valid", W'(nv), 32'd0);

        // Back-to-back: second start in the valid cycle
        start_op(OP_MUL, 32'd3, 32'd4);
        wait_done(res, lat, bcnt);
        chk("b2b_first", res, 32'd12);
        chk("b2b_first_latency", W'(lat), 32'd33);
        start_op(OP_MUL, 32'd5, 32'd6);
        wait_done(res, lat, bcnt);
        chk("b2b_second", res, 32'd30);
        chk("b2b_second_latency", W'(lat), 32'd33);

        // Reset mid-CALC
        start_op(OP_DIVU, 32'd1000, 32'd7);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_valid", {31'b0, valid}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        count_valids(40, nv);
        chk("rst_no_valid", W'(nv), 32'd0);
        chk("rst_result_stays", result, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
